// File: rtl/cursor_ctrl.sv
// Grid cursor driven by held direction levels with per-axis auto-repeat.
// Click edges latch the pre-move cursor position as a selection.
module cursor_axis #(
  parameter int N    = 20,
  parameter int INIT = 7,
  parameter int WRAP = 0,
  parameter int RD   = 25000000,
  parameter int RR   = 5000000,
  parameter int W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         neg,
  input  logic         pos,
  output logic [W-1:0] coord,
  output logic         chg
);
  localparam int CW = $clog2((RD > RR ? RD : RR) + 1);
  localparam logic [W-1:0] MAX = W'(N - 1);
  localparam logic [W-1:0] INIT_C = W'(INIT);
  localparam logic [CW-1:0] LD_DELAY = CW'(RD - 1);
  localparam logic [CW-1:0] LD_RATE = CW'(RR - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  typedef enum logic [1:0] {D_NONE, D_NEG, D_POS} dir_t;

  state_t        state;
  dir_t          dir;
  dir_t          last;
  logic [CW-1:0] cnt;
  logic [W-1:0]  nxt;
  logic          press;

  always_comb begin
    dir = D_NONE;
    unique case (1'b1)
      (neg & ~pos): dir = D_NEG;
      (pos & ~neg): dir = D_POS;
      default:      dir = D_NONE;
    endcase
  end

  // Edge test happens before the add/subtract, so no modular overflow.
  always_comb begin
    nxt = coord;
    if (dir == D_NEG)
      nxt = (coord == '0) ? ((WRAP != 0) ? MAX : coord)
                          : coord - W'(1);
    else if (dir == D_POS)
      nxt = (coord == MAX) ? ((WRAP != 0) ? '0 : coord)
                           : coord + W'(1);
  end

  assign press = (dir != D_NONE) &&
                 ((state == IDLE) || (dir != last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= D_NONE;
      cnt   <= '0;
      coord <= INIT_C;
      chg   <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (run) begin
        if (dir == D_NONE) begin
          state <= IDLE;
          last  <= D_NONE;
          cnt   <= '0;
        end else if (press) begin
          coord <= nxt;
          chg   <= (nxt != coord);
          cnt   <= LD_DELAY;
          last  <= dir;
          state <= HOLD;
        end else if (cnt == '0) begin
          coord <= nxt;
          chg   <= (nxt != coord);
          cnt   <= LD_RATE;
          state <= REPEAT;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end
endmodule

module cursor_ctrl #(
  parameter int COLS         = 20,
  parameter int ROWS         = 15,
  parameter int INIT_X       = 7,
  parameter int INIT_Y       = 7,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int XW           = 5,
  parameter int YW           = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          left,
  input  logic          right,
  input  logic          up,
  input  logic          down,
  input  logic          click,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          moved,
  output logic          sel_valid,
  output logic [XW-1:0] sel_x,
  output logic [YW-1:0] sel_y,
  output logic [3:0]    at_edge
);
  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

  logic [1:0] sync;
  logic       run;
  logic       x_chg;
  logic       y_chg;
  logic       click_q;

  // Two-stage release keeps the FSMs idle until reset exit is clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], 1'b1};
  end

  assign run = sync[1];

  cursor_axis #(
    .N(COLS), .INIT(INIT_X), .WRAP(WRAP),
    .RD(REPEAT_DELAY), .RR(REPEAT_RATE), .W(XW)
  ) u_x (
    .clk(clk), .rst(rst), .run(run),
    .neg(left), .pos(right),
    .coord(cur_x), .chg(x_chg)
  );

  cursor_axis #(
    .N(ROWS), .INIT(INIT_Y), .WRAP(WRAP),
    .RD(REPEAT_DELAY), .RR(REPEAT_RATE), .W(YW)
  ) u_y (
    .clk(clk), .rst(rst), .run(run),
    .neg(up), .pos(down),
    .coord(cur_y), .chg(y_chg)
  );

  assign moved = x_chg | y_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      click_q   <= 1'b0;
      sel_valid <= 1'b0;
      sel_x     <= '0;
      sel_y     <= '0;
    end else begin
      sel_valid <= 1'b0;
      if (run) begin
        click_q <= click;
        if (click & ~click_q) begin
          sel_valid <= 1'b1;
          sel_x     <= cur_x;
          sel_y     <= cur_y;
        end
      end
    end
  end

  assign at_edge = {cur_x == '0, cur_x == XMAX,
                    cur_y == '0, cur_y == YMAX};
endmodule

// File: tb/tb_cursor_ctrl.sv
// Cursor controller bench: clamp and wrap instances share stimulus,
// expectations come from a press-age reference model via queues.
module tb_cursor_ctrl;
  localparam int RD   = 4;
  localparam int RR   = 2;
  localparam int COLS = 20;
  localparam int ROWS = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
  logic click = 1'b0;
  logic [4:0] x0, y0, sx0, sy0, x1, y1, sx1, sy1;
  logic mv0, sv0, mv1, sv1;
  logic [3:0] e0, e1;

  always #5 clk = ~clk;

  cursor_ctrl #(
    .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) u_dut (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .up(up), .down(down), .click(click),
    .cur_x(x0), .cur_y(y0), .moved(mv0),
    .sel_valid(sv0), .sel_x(sx0), .sel_y(sy0),
    .at_edge(e0)
  );

  cursor_ctrl #(
    .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) u_wrap (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .up(up), .down(down), .click(click),
    .cur_x(x1), .cur_y(y1), .moved(mv1),
    .sel_valid(sv1), .sel_x(sx1), .sel_y(sy1),
    .at_edge(e1)
  );

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic       mv;
    logic       sv;
    logic [4:0] sx;
    logic [4:0] sy;
    logic [3:0] e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // reference model state; index 0 = clamp, 1 = wrap
  int age[2];
  int pdir[2];
  int cx[2], cy[2], csx[2], csy[2];
  bit mvm[2], svm[2];
  bit cprev;
  int run_cnt;

  task automatic check(string name, exp_t got, exp_t ex);
    tests++;
    if (got !== ex) begin
      fails++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d mv=%0b sv=%0b sel=(%0d,%0d) edge=%b exp x=%0d y=%0d mv=%0b sv=%0b sel=(%0d,%0d) edge=%b",
               name, cyc_n, got.x, got.y, got.mv, got.sv, got.sx,
               got.sy, got.e, ex.x, ex.y, ex.mv, ex.sv, ex.sx,
               ex.sy, ex.e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (q0.size() > 0 && q1.size() > 0) begin
        check("clamp", {x0, y0, mv0, sv0, sx0, sy0, e0},
              q0.pop_front());
        check("wrap", {x1, y1, mv1, sv1, sx1, sy1, e1},
              q1.pop_front());
      end
    end
  end

  function automatic int stepc(int c, int dir, int n, bit wrap);
    if (dir < 0) return (c == 0) ? (wrap ? n - 1 : 0) : c - 1;
    if (dir > 0) return (c == n - 1) ? (wrap ? 0 : c) : c + 1;
    return c;
  endfunction

  // step when a press starts, after RD held edges, then every RR
  function automatic bit fires(int a, int dir);
    if (dir == 0) begin
      age[a]  = -1;
      pdir[a] = 0;
      return 1'b0;
    end
    if (age[a] < 0 || dir != pdir[a]) begin
      age[a]  = 0;
      pdir[a] = dir;
      return 1'b1;
    end
    age[a]++;
    return (age[a] == RD) ||
           (age[a] > RD && (age[a] - RD) % RR == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      age[k] = -1; pdir[k] = 0;
      cx[k] = 7; cy[k] = 7; csx[k] = 0; csy[k] = 0;
      mvm[k] = 0; svm[k] = 0;
    end
    cprev = 0;
    run_cnt = 0;
  endtask

  task automatic push();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.x  = 5'(cx[k]);
      e.y  = 5'(cy[k]);
      e.mv = mvm[k];
      e.sv = svm[k];
      e.sx = 5'(csx[k]);
      e.sy = 5'(csy[k]);
      e.e  = {cx[k] == 0, cx[k] == COLS - 1,
              cy[k] == 0, cy[k] == ROWS - 1};
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic model_edge(bit l, bit r, bit u, bit d, bit c, bit rs);
    int dx, dy, nx, ny;
    bit fx, fy;
    if (!rs) begin
      model_reset();
    end else if (run_cnt < 2) begin
      run_cnt++;
      for (int k = 0; k < 2; k++) begin mvm[k] = 0; svm[k] = 0; end
    end else begin
      dx = int'(r) - int'(l);
      dy = int'(d) - int'(u);
      fx = fires(0, dx);
      fy = fires(1, dy);
      for (int k = 0; k < 2; k++) begin
        nx = fx ? stepc(cx[k], dx, COLS, k == 1) : cx[k];
        ny = fy ? stepc(cy[k], dy, ROWS, k == 1) : cy[k];
        mvm[k] = (nx != cx[k]) || (ny != cy[k]);
        svm[k] = c && !cprev;
        if (svm[k]) begin csx[k] = cx[k]; csy[k] = cy[k]; end
        cx[k] = nx;
        cy[k] = ny;
      end
      cprev = c;
    end
    push();
  endtask

  task automatic cyc(bit l, bit r, bit u, bit d, bit c, bit rs = 1'b1);
    @(negedge clk);
    left = l; right = r; up = u; down = d; click = c;
    rst = rs;
    model_edge(l, r, u, d, c, rs);
    if (!rs) begin
      #1;
      tests++;
      if (x0 !== 5'd7 || y0 !== 5'd7 || mv0 !== 1'b0 ||
          sv0 !== 1'b0 || x1 !== 5'd7 || y1 !== 5'd7) begin
        fails++;
        $display("FAIL async_reset got (%0d,%0d) mv=%0b sv=%0b wrap (%0d,%0d) exp (7,7) mv=0 sv=0",
                 x0, y0, mv0, sv0, x1, y1);
      end
    end
  endtask

  initial begin
    logic [4:0] p;
    int len;
    model_reset();
    #2 rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (21) cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (8) cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    for (int s = 0; s < 60; s++) begin
      p   = 5'($urandom);
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 19) == 0)
        cyc(p[0], p[1], p[2], p[3], p[4], 1'b0);
      else
        repeat (len) cyc(p[0], p[1], p[2], p[3], p[4]);
    end
    repeat (3) cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d pending exp 0",
               q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  COLS  20  grid width in cells, >= 2
  ROWS  15  grid height in cells, >= 2
  INIT_X  7  reset column, < COLS
  INIT_Y  7  reset row, < ROWS
  WRAP  0  0 = clamp at edges, 1 = wrap to opposite edge
  REPEAT_DELAY  25000000  held cycles before first auto-repeat step, >= 1
  REPEAT_RATE  5000000  cycles between auto-repeat steps, >= 1
  XW  5  cursor column width, 2^XW >= COLS
  YW  5  cursor row width, 2^YW >= ROWS
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  system clock; the only clock
  rst  in  1  asynchronous, active-low reset; 0 = reset
  left  in  1  level, direction held, synchronous to clk
  right  in  1  level, direction held
  up  in  1  level, direction held
  down  in  1  level, direction held
  click  in  1  level, select button held
  cur_x  out  XW  current column
  cur_y  out  YW  current row
  moved  out  1  one-cycle pulse, cursor changed this cycle
  sel_valid  out  1  one-cycle pulse, selection event
  sel_x  out  XW  column captured at selection
  sel_y  out  YW  row captured at selection
  at_edge  out  4  {left, right, top, bottom} edge flags, combinational from cur_x/cur_y

Function
REQ-003 X axis (left/right) and Y axis (up/down) SHALL each run an independent FSM: IDLE, HOLD, REPEAT.
REQ-004 Net axis direction: exactly one input of the pair high -> that direction; both or neither -> none.
REQ-005 IDLE + direction d: step once in d at the next clk edge, load counter with REPEAT_DELAY-1, go to HOLD.
REQ-006 HOLD, direction unchanged: decrement counter; at 0, step once, load REPEAT_RATE-1, go to REPEAT.
REQ-007 REPEAT, direction unchanged: decrement counter; at 0, step once, reload REPEAT_RATE-1, stay in REPEAT.
REQ-008 HOLD/REPEAT with direction none -> IDLE, no step; direction reversed -> act as IDLE with the new direction (immediate step, HOLD).
REQ-009 Step latency: registered cur_x/cur_y update on the first clk edge sampling the new direction (1 cycle).
REQ-010 WRAP=0: step toward an edge when already at it (x=0 left, x=COLS-1 right, y=0 up, y=ROWS-1 down) SHALL not change the coordinate; FSM timing continues unchanged.
REQ-011 WRAP=1: left at 0 -> COLS-1; right at COLS-1 -> 0; up at 0 -> ROWS-1; down at ROWS-1 -> 0.
REQ-012 Arithmetic: coordinates SHALL never leave [0,COLS-1]/[0,ROWS-1]; compare against edge before add/subtract, no modular overflow of XW/YW.
REQ-013 X and Y steps in the same cycle SHALL both apply (diagonal move), as a single moved pulse.
REQ-014 moved SHALL be 1 for exactly the cycle after an edge where cur_x or cur_y changed value; clamped no-op steps give moved=0.
REQ-015 click SHALL be edge-detected via a registered previous value; 0->1 transition -> sel_valid=1 for one cycle.
REQ-016 sel_x/sel_y SHALL capture cur_x/cur_y as they were before any step in the click cycle, and hold until the next selection.
REQ-017 Held click SHALL generate no further sel_valid; click has no auto-repeat.
REQ-018 at_edge bits SHALL reflect cur_x==0, cur_x==COLS-1, cur_y==0, cur_y==ROWS-1 regardless of WRAP.

Reset
REQ-019 rst=0 SHALL asynchronously force: cur_x=INIT_X, cur_y=INIT_Y, both FSMs IDLE, counters 0, moved=0, sel_valid=0, sel_x=0, sel_y=0, click history=0.
REQ-020 Reset mid-hold: after rst release with a direction still held, the FSM SHALL treat it as a new press (one immediate step, then full REPEAT_DELAY).
REQ-021 Reset deassertion SHALL be synchronised to clk before FSMs leave IDLE (2-stage release).

Verification (REPEAT_DELAY=4, REPEAT_RATE=2, defaults otherwise)
REQ-022 Reset, release, idle inputs -> cur=(7,7), moved=0, sel_valid=0, at_edge=0000.
REQ-023 right held 10 cycles -> x=8 after 1 cycle, 9 after +4, then +1 every 2 cycles; x=11 at release, moved pulses match.
REQ-024 WRAP=0, x=0, left pulsed -> x stays 0, moved=0, at_edge[3]=1; WRAP=1 same stimulus -> x=19, moved=1.
REQ-025 left+right held together, up held -> x unchanged, y decrements per REQ-005..007; then right+down -> diagonal step, single moved pulse.
REQ-026 click held 5 cycles while right pressed on the same edge -> one sel_valid, sel=(pre-move x, y), cur_x advanced.
REQ-027 rst asserted during REPEAT with down held -> cur=(7,7) immediately; after release one step to y=8, next step only after 4 cycles.
